// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode decoder types and constants: decoder states, prefix and
// overrun byte values, and the 10-bit key event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PFX_E0   = 2'd1,
    PFX_F0   = 2'd2,
    PFX_E0F0 = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_OVR0    = 8'h00;
  localparam logic [7:0] PS2_OVR1    = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] key;
  } ps2_evt_t;

  function automatic logic ps2_is_ovr(input logic [7:0] b);
    return (b == PS2_OVR0) || (b == PS2_OVR1);
  endfunction

endpackage

// File: rtl/ps2_scan_ctrl_if.sv
// Byte-receiver and key-event consumer handshake of ps2_scan_ctrl.
interface ps2_scan_ctrl_if;
  logic       i_cap;
  logic [7:0] i_dap;
  logic       o_spa;
  logic       o_valid;
  logic [7:0] o_key;
  logic       o_ext;
  logic       o_brk;
  logic       i_ack;

  modport slave (
    input  i_cap, i_dap, i_ack,
    output o_spa, o_valid, o_key, o_ext, o_brk
  );

  modport master (
    output i_cap, i_dap, i_ack,
    input  o_spa, o_valid, o_key, o_ext, o_brk
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Key-event FIFO, power-of-two DEPTH; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  logic     i_pop,
  input  ps2_evt_t i_din,
  output ps2_evt_t o_dout,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  ps2_evt_t      mem_q [DEPTH];
  logic          do_push_s, do_pop_s;

  assign o_full    = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty   = (cnt_q == (AW+1)'(0));
  assign do_pop_s  = i_pop & ~o_empty;
  assign do_push_s = i_push & (~o_full | do_pop_s);
  assign o_dout    = mem_q[rd_q];

  // Storage, pointers (wrap naturally at DEPTH) and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= i_din;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop_s) rd_q <= rd_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scancode prefix decoder with key-event queue. Define PS2_SCAN_FIFO_EN
// for a FIFO_DEPTH-entry event FIFO; otherwise a single event register is used.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  ps2_scan_ctrl_if.slave  bus,
  output logic            o_err,
  output logic [7:0]      o_err_cnt
);
  ps2_state_e state_q, state_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q;
  logic       push_s, pop_s, spa_s, valid_s;
  ps2_evt_t   evt_s, head_s;

  // Decoder state, error pulse and saturating error counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Next state, error detection and event emission for each captured byte.
  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    push_s    = 1'b0;
    evt_s.key = bus.i_dap;
    evt_s.ext = (state_q == PFX_E0) || (state_q == PFX_E0F0);
    evt_s.brk = (state_q == PFX_F0) || (state_q == PFX_E0F0);
    if (bus.i_cap) begin
      if (!spa_s) begin
        err_d = 1'b1;
      end else if (ps2_is_ovr(bus.i_dap)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (bus.i_dap == PS2_PFX_EXT) begin
        state_d = PFX_E0;
        err_d   = (state_q != IDLE);
      end else if (bus.i_dap == PS2_PFX_BRK) begin
        case (state_q)
          IDLE:    state_d = PFX_F0;
          PFX_E0:  state_d = PFX_E0F0;
          default: err_d   = 1'b1;
        endcase
      end else begin
        push_s  = 1'b1;
        state_d = IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  assign pop_s = valid_s & bus.i_ack;

`ifdef PS2_SCAN_FIFO_EN
  logic full_s, empty_s;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ps2_scan_ctrl: FIFO_DEPTH must be a power of two in 2..16");
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_s),
    .i_pop   (pop_s),
    .i_din   (evt_s),
    .o_dout  (head_s),
    .o_full  (full_s),
    .o_empty (empty_s)
  );

  assign valid_s = ~empty_s;
  assign spa_s   = ~full_s;
`else
  ps2_evt_t evt_q;
  logic     valid_q;

  // Single-entry event holding register; a new push replaces a popped head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      evt_q   <= '0;
      valid_q <= 1'b0;
    end else if (push_s) begin
      evt_q   <= evt_s;
      valid_q <= 1'b1;
    end else if (pop_s) begin
      valid_q <= 1'b0;
    end
  end

  assign head_s  = evt_q;
  assign valid_s = valid_q;
  assign spa_s   = ~valid_q | bus.i_ack;
`endif

  assign bus.o_valid = valid_s;
  assign bus.o_key   = head_s.key;
  assign bus.o_ext   = head_s.ext;
  assign bus.o_brk   = head_s.brk;
  assign bus.o_spa   = spa_s;
  assign o_err       = err_q;
  assign o_err_cnt   = err_cnt_q;
endmodule
